note_i2s_tx: RTL and testbench

Speaker-side consumer of the per-channel note divisors produced by the frequency-select stage. It converts `note_div_left`/`note_div_right` into square-wave 16-bit PCM samples, scaled by volume, and serializes them onto the Pmod I2S2 DAC interface (MCLK, LRCK, SCK, SDIN). It sits between the frequency-select logic and the board's audio pins, and emits a per-frame strobe that melody sequencers can use as a time base.

---
 rtl/note_i2s_tx.sv | 120 ++++++++++++
 tb/tb_note_i2s_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_i2s_tx.sv
// note_i2s_tx: square-wave note generator driving a Pmod I2S2 DAC (MCLK/LRCK/SCK/SDIN).
// Optional macro NOTE_I2S_TX_VOL_EN: amplitude = volume << AMP_SHIFT; otherwise fixed 0x4000.
module note_i2s_tx #(
   parameter int DIV_W     = 22,
   parameter int AMP_SHIFT = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] note_div_left,
   input  logic [DIV_W-1:0] note_div_right,
   input  logic [2:0]       volume,
   output logic             audio_mclk,
   output logic             audio_lrck,
   output logic             audio_sck,
   output logic             audio_sdin,
   output logic             frame_tick
);

   logic [9:0]       cnt_r;
   logic [9:0]       cnt_s;
   logic [DIV_W-1:0] div_s  [2];
   logic [DIV_W-1:0] tcnt_r [2];
   logic [1:0]       phase_r;
   logic [15:0]      amp_s;
   logic [15:0]      sample_l_s;
   logic [15:0]      sample_r_s;
   logic [15:0]      shadow_l_r;
   logic [15:0]      shadow_r_r;
   logic             sdin_r;
   logic             frame_tick_r;

   // Square-wave PCM value; a zero divisor means silence regardless of phase.
   function automatic logic [15:0] tone_sample(input logic [DIV_W-1:0] div,
                                               input logic             phase,
                                               input logic [15:0]      amp);
      logic [15:0] s;
      if (div == '0) begin
         s = 16'h0000;
      end else if (phase) begin
         s = amp;
      end else begin
         s = 16'h0000 - amp;
      end
      return s;
   endfunction

   // I2S one-bit delay: slot k (1..16) carries word bit [16-k], all other slots are 0.
   function automatic logic slot_bit(input logic [4:0] slot, input logic [15:0] word);
      logic       b;
      logic [3:0] idx;
      idx = 4'd15 - 4'(slot - 5'd1);
      if ((slot >= 5'd1) && (slot <= 5'd16)) begin
         b = word[idx];
      end else begin
         b = 1'b0;
      end
      return b;
   endfunction

`ifdef NOTE_I2S_TX_VOL_EN
   assign amp_s = 16'(volume) << AMP_SHIFT;
`else
   logic vol_unused_s;
   assign vol_unused_s = ^volume;
   assign amp_s        = 16'h4000;
`endif

   assign div_s[0]   = note_div_left;
   assign div_s[1]   = note_div_right;
   assign sample_l_s = tone_sample(div_s[0], phase_r[0], amp_s);
   assign sample_r_s = tone_sample(div_s[1], phase_r[1], amp_s);
   assign cnt_s      = cnt_r + 10'd1;

   // Half-period tone counters; the >= wrap lets a shrinking divisor take effect next cycle.
   always_ff @(posedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (!rst_n) begin
            tcnt_r[ch]  <= '0;
            phase_r[ch] <= 1'b0;
         end else if (div_s[ch] == '0) begin
            tcnt_r[ch]  <= '0;
            phase_r[ch] <= 1'b0;
         end else if (tcnt_r[ch] >= (div_s[ch] - DIV_W'(1))) begin
            tcnt_r[ch]  <= '0;
            phase_r[ch] <= ~phase_r[ch];
         end else begin
            tcnt_r[ch]  <= tcnt_r[ch] + DIV_W'(1);
         end
      end
   end

   // Frame counter, shadow capture at wrap, serial data and frame strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r        <= 10'd0;
         shadow_l_r   <= 16'h0000;
         shadow_r_r   <= 16'h0000;
         sdin_r       <= 1'b0;
         frame_tick_r <= 1'b0;
      end else begin
         cnt_r        <= cnt_s;
         frame_tick_r <= (cnt_r == 10'd1023);
         if (cnt_r == 10'd1023) begin
            shadow_l_r <= sample_l_s;
            shadow_r_r <= sample_r_s;
         end
         // Data moves only when SCK falls; the DAC samples it on the next rising edge.
         if (cnt_s[3:0] == 4'd0) begin
            sdin_r <= slot_bit(cnt_s[8:4], cnt_s[9] ? shadow_r_r : shadow_l_r);
         end
      end
   end

   assign audio_mclk = cnt_r[1];
   assign audio_sck  = cnt_r[3];
   assign audio_lrck = cnt_r[9];
   assign audio_sdin = sdin_r;
   assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_note_i2s_tx.sv
// Directed, table-driven bench for note_i2s_tx: decodes I2S frames and checks clocks,
// reset behaviour, sample words and the shrinking-divisor corner case.
module tb_note_i2s_tx;

   logic        clk;
   logic        rst_n;
   logic [21:0] note_div_left;
   logic [21:0] note_div_right;
   logic [2:0]  volume;
   logic        audio_mclk;
   logic        audio_lrck;
   logic        audio_sck;
   logic        audio_sdin;
   logic        frame_tick;

   int n_checks;
   int n_fail;

   note_i2s_tx #(.DIV_W(22), .AMP_SHIFT(12)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .note_div_left  (note_div_left),
      .note_div_right (note_div_right),
      .volume         (volume),
      .audio_mclk     (audio_mclk),
      .audio_lrck     (audio_lrck),
      .audio_sck      (audio_sck),
      .audio_sdin     (audio_sdin),
      .frame_tick     (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef NOTE_I2S_TX_VOL_EN
   localparam logic [15:0] P0 = 16'h0000, N0 = 16'h0000;
   localparam logic [15:0] P1 = 16'h1000, N1 = 16'hF000;
   localparam logic [15:0] P3 = 16'h3000, N3 = 16'hD000;
   localparam logic [15:0] P5 = 16'h5000, N5 = 16'hB000;
   localparam logic [15:0] P7 = 16'h7000, N7 = 16'h9000;
`else
   localparam logic [15:0] P0 = 16'h4000, N0 = 16'hC000;
   localparam logic [15:0] P1 = 16'h4000, N1 = 16'hC000;
   localparam logic [15:0] P3 = 16'h4000, N3 = 16'hC000;
   localparam logic [15:0] P5 = 16'h4000, N5 = 16'hC000;
   localparam logic [15:0] P7 = 16'h4000, N7 = 16'hC000;
`endif

   typedef struct {
      logic [21:0] div_l;
      logic [21:0] div_r;
      logic [2:0]  vol;
      logic [15:0] lp, ln, rp, rn;
      bit          alt_l, alt_r, same;
      int          frames;
   } vec_t;

   vec_t vecs[5];

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_true(input string name, input bit cond, input logic [31:0] act);
      n_checks++;
      if (!cond) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, condition not met", name, act);
      end
   endtask

   task automatic apply_reset(input logic [21:0] dl, input logic [21:0] dr, input logic [2:0] v);
      @(negedge clk);
      note_div_left  = dl;
      note_div_right = dr;
      volume         = v;
      rst_n          = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Leaves the bench at the negedge where frame_tick is high (or fails on timeout).
   task automatic wait_tick();
      int n = 0;
      while (frame_tick !== 1'b1 && n < 2100) begin
         @(negedge clk);
         n++;
      end
      check_true("frame_tick_wait", frame_tick === 1'b1, 32'(n));
   endtask

   // Decodes one full frame: 64 SCK slots sampled mid-bit (SCK high).
   task automatic capture_frame(output logic [15:0] lw, output logic [15:0] rw, output bit pad_ok);
      logic [63:0] slots;
      logic [63:0] mask;
      slots = '0;
      mask  = '0;
      wait_tick();
      for (int i = 0; i < 1024; i++) begin
         if (i % 16 == 8) slots[i / 16] = audio_sdin;
         @(negedge clk);
      end
      for (int k = 1; k <= 16; k++) begin
         lw[16 - k] = slots[k];
         rw[16 - k] = slots[32 + k];
      end
      mask[0]  = 1'b1;
      mask[32] = 1'b1;
      for (int k = 17; k < 32; k++) begin
         mask[k]      = 1'b1;
         mask[32 + k] = 1'b1;
      end
      pad_ok = ((slots & mask) == 64'd0);
   endtask

   initial begin
      logic [15:0] lw, rw, prev_l, prev_r;
      bit          pad_ok;
      int          err_mclk, err_sck, err_lrck, err_tick, first_lrck, first_tick;
      logic [10:0] kv;

      n_checks = 0;
      n_fail   = 0;

      vecs[0] = '{22'd1024, 22'd0,     3'd7, P7, N7, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 3};
      vecs[1] = '{22'd0,    22'd1024,  3'd5, 16'h0000, 16'h0000, P5, N5, 1'b0, 1'b1, 1'b0, 3};
      vecs[2] = '{22'd47801, 22'd47801, 3'd3, P3, N3, P3, N3, 1'b0, 1'b0, 1'b1, 3};
      vecs[3] = '{22'd47801, 22'd47801, 3'd0, P0, N0, P0, N0, 1'b0, 1'b0, 1'b1, 4};
      vecs[4] = '{22'd2048, 22'd1024,  3'd1, P1, N1, P1, N1, 1'b0, 1'b1, 1'b0, 3};

      rst_n          = 1'b0;
      note_div_left  = 22'd0;
      note_div_right = 22'd0;
      volume         = 3'd0;
      repeat (3) @(negedge clk);
      rst_n          = 1'b1;
      note_div_left  = 22'd1024;
      volume         = 3'd7;
      repeat (1300) @(negedge clk);

      // Reset held 3 cycles during active output.
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq($sformatf("reset_outputs_%0d", c),
                  {27'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_tick}, 32'd0);
      end
      rst_n = 1'b1;

      err_mclk = 0; err_sck = 0; err_lrck = 0; err_tick = 0;
      first_lrck = -1; first_tick = -1;
      for (int k = 1; k <= 1024; k++) begin
         @(negedge clk);
         kv = 11'(k);
         if (audio_mclk !== kv[1]) err_mclk++;
         if (audio_sck  !== kv[3]) err_sck++;
         if (audio_lrck !== kv[9]) err_lrck++;
         if (frame_tick !== (k == 1024)) err_tick++;
         if (audio_lrck === 1'b1 && first_lrck < 0) first_lrck = k;
         if (frame_tick === 1'b1 && first_tick < 0) first_tick = k;
      end
      check_eq("mclk_pattern_errors", 32'(err_mclk), 32'd0);
      check_eq("sck_pattern_errors", 32'(err_sck), 32'd0);
      check_eq("lrck_pattern_errors", 32'(err_lrck), 32'd0);
      check_eq("frame_tick_pattern_errors", 32'(err_tick), 32'd0);
      check_eq("lrck_first_rise", 32'(first_lrck), 32'd512);
      check_eq("frame_tick_first", 32'(first_tick), 32'd1024);

      // Table-driven sample checks; first frame after reset samples phase 0 (negative).
      for (int i = 0; i < 5; i++) begin
         apply_reset(vecs[i].div_l, vecs[i].div_r, vecs[i].vol);
         prev_l = 16'h0000;
         prev_r = 16'h0000;
         for (int f = 0; f < vecs[i].frames; f++) begin
            capture_frame(lw, rw, pad_ok);
            if (f == 0) begin
               check_eq($sformatf("v%0d_left_first", i), 32'(lw), 32'(vecs[i].ln));
               check_eq($sformatf("v%0d_right_first", i), 32'(rw), 32'(vecs[i].rn));
            end else begin
               check_true($sformatf("v%0d_f%0d_left_value", i, f),
                          (lw === vecs[i].lp) || (lw === vecs[i].ln), 32'(lw));
               check_true($sformatf("v%0d_f%0d_right_value", i, f),
                          (rw === vecs[i].rp) || (rw === vecs[i].rn), 32'(rw));
               if (vecs[i].alt_l) check_true($sformatf("v%0d_f%0d_left_alternates", i, f),
                                             lw !== prev_l, 32'(lw));
               if (vecs[i].alt_r) check_true($sformatf("v%0d_f%0d_right_alternates", i, f),
                                             rw !== prev_r, 32'(rw));
            end
            check_true($sformatf("v%0d_f%0d_pad_slots_zero", i, f), pad_ok, {16'(lw), 16'(rw)});
            if (vecs[i].same) check_eq($sformatf("v%0d_f%0d_left_eq_right", i, f), 32'(lw), 32'(rw));
            prev_l = lw;
            prev_r = rw;
         end
      end

      // Divisor shrinks 47801 -> 4 with the tone counter near 40900: phase must
      // toggle on the next edge (W-9), then at W-5 and W-1, so the frame W sample is positive.
      apply_reset(22'd47801, 22'd47801, 3'd3);
      for (int j = 0; j < 39; j++) begin
         wait_tick();
         @(negedge clk);
      end
      repeat (1013) @(negedge clk);
      note_div_left = 22'd4;
      capture_frame(lw, rw, pad_ok);
      check_eq("shrink_left_first_frame", 32'(lw), 32'(P3));
      check_eq("shrink_right_unchanged", 32'(rw), 32'(N3));
      capture_frame(lw, rw, pad_ok);
      check_eq("shrink_left_second_frame", 32'(lw), 32'(P3));
      check_eq("shrink_right_second_frame", 32'(rw), 32'(N3));
      check_true("shrink_pad_slots_zero", pad_ok, {16'(lw), 16'(rw)});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
